// File: rtl/cpu_controller_fsm.sv
// Moore control FSM for the simple CPU: sequences decode, operand fetch, execute and
// register write-back, driving the decoder's nsel and all datapath strobes.
`timescale 1ns/1ps
module cpu_controller_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    StWait   = 4'd0,
    StDecode = 4'd1,
    StWrImm  = 4'd2,
    StGetA   = 4'd3,
    StGetB   = 4'd4,
    StExec   = 4'd5,
    StWrReg  = 4'd6,
    StHalt   = 4'd7
  } state_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;
  localparam logic [1:0] OpCmp  = 2'b01;
  localparam logic [1:0] OpImm  = 2'b10;
  localparam logic [1:0] OpReg  = 2'b00;

  state_e r_state;
  state_e w_state_next;
  state_e w_bail;

  // Destination for unsupported encodings.
  assign w_bail = ILLEGAL_HALT ? StHalt : StWait;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StWait;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StWait:   if (s) w_state_next = StDecode;
      StDecode: begin
        if (opcode == OpcMov && op == OpImm)      w_state_next = StWrImm;
        else if (opcode == OpcMov && op == OpReg) w_state_next = StGetB;
        else if (opcode == OpcAlu)                w_state_next = StGetA;
        else                                      w_state_next = w_bail;
      end
      StWrImm:  w_state_next = StWait;
      StGetA:   w_state_next = StGetB;
      StGetB:   w_state_next = StExec;
      StExec: begin
        if (opcode == OpcMov)                   w_state_next = StWrReg;
        else if (opcode == OpcAlu && op == OpCmp) w_state_next = StWait;
        else if (opcode == OpcAlu)              w_state_next = StWrReg;
        else                                    w_state_next = w_bail;
      end
      StWrReg:  w_state_next = StWait;
      StHalt:   w_state_next = StHalt;
      default:  w_state_next = StWait;
    endcase
  end

  // Outputs depend on state only, except EXEC which re-reads the held opcode/op.
  always_comb begin
    w     = 1'b0;
    nsel  = 2'b00;
    vsel  = 2'b00;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    unique case (r_state)
      StWait:  w = 1'b1;
      StWrImm: begin
        nsel  = 2'b00;
        vsel  = 2'b10;
        write = 1'b1;
      end
      StGetA: begin
        nsel  = 2'b00;
        loada = 1'b1;
      end
      StGetB: begin
        nsel  = 2'b10;
        loadb = 1'b1;
      end
      StExec: begin
        if (opcode == OpcMov) begin
          asel  = 1'b1;
          loadc = 1'b1;
        end else if (opcode == OpcAlu && op == OpCmp) begin
          loads = 1'b1;
        end else if (opcode == OpcAlu) begin
          loadc = 1'b1;
        end
      end
      StWrReg: begin
        nsel  = 2'b01;
        vsel  = 2'b00;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// Scoreboard bench for cpu_controller_fsm: two instances (ILLEGAL_HALT=0/1) share stimulus;
// per-cycle expected output vectors are queued at drive time and popped after each edge.
`timescale 1ns/1ps
module tb_cpu_controller_fsm;

  logic       clk;
  logic       reset_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;

  logic       w0, write0, loada0, loadb0, loadc0, loads0, asel0, bsel0;
  logic [1:0] nsel0, vsel0;
  logic [3:0] st0;
  logic       w1, write1, loada1, loadb1, loadc1, loads1, asel1, bsel1;
  logic [1:0] nsel1, vsel1;
  logic [3:0] st1;

  int n_checks;
  int n_errors;
  int n_writes;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  cpu_controller_fsm #(.ILLEGAL_HALT(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w0), .nsel(nsel0), .vsel(vsel0), .write(write0), .loada(loada0), .loadb(loadb0),
    .loadc(loadc0), .loads(loads0), .asel(asel0), .bsel(bsel0), .state_dbg(st0)
  );

  cpu_controller_fsm #(.ILLEGAL_HALT(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w1), .nsel(nsel1), .vsel(vsel1), .write(write1), .loada(loada1), .loadb(loadb1),
    .loadc(loadc1), .loads(loads1), .asel(asel1), .bsel(bsel1), .state_dbg(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {state, w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel}.
  function automatic logic [15:0] vec0();
    return {st0, w0, nsel0, vsel0, write0, loada0, loadb0, loadc0, loads0, asel0, bsel0};
  endfunction

  function automatic logic [15:0] vec1();
    return {st1, w1, nsel1, vsel1, write1, loada1, loadb1, loadc1, loads1, asel1, bsel1};
  endfunction

  // Expected Moore outputs for a state, from the output table.
  function automatic logic [15:0] exp_vec(input int st, input logic [2:0] opc,
                                          input logic [1:0] o);
    logic       ew, ewr, ela, elb, elc, els, eas;
    logic [1:0] ens, evs;
    ew = 0; ewr = 0; ela = 0; elb = 0; elc = 0; els = 0; eas = 0; ens = 0; evs = 0;
    case (st)
      0: ew = 1;
      2: begin evs = 2'b10; ewr = 1; end
      3: ela = 1;
      4: begin ens = 2'b10; elb = 1; end
      5: begin
        if (opc == 3'b110) begin eas = 1; elc = 1; end
        else if (o == 2'b01) els = 1;
        else elc = 1;
      end
      6: begin ens = 2'b01; ewr = 1; end
      default: ;
    endcase
    return {st[3:0], ew, ens, evs, ewr, ela, elb, elc, els, eas, 1'b0};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_both(input int st);
    q0.push_back(exp_vec(st, opcode, op));
    q1.push_back(exp_vec(st, opcode, op));
  endtask

  // One clock edge, then compare both instances against the head of their queues.
  task automatic step(input string tag);
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (write0) n_writes++;
    if (q0.size() == 0) check_eq({tag, "/q0_empty"}, vec0(), 16'hxxxx);
    else begin e = q0.pop_front(); check_eq({tag, "/h0"}, vec0(), e); end
    if (q1.size() == 0) check_eq({tag, "/q1_empty"}, vec1(), 16'hxxxx);
    else begin e = q1.pop_front(); check_eq({tag, "/h1"}, vec1(), e); end
  endtask

  task automatic run_instr(input string tag, input logic [2:0] opc, input logic [1:0] o,
                           input bit hold_s, input int exp_writes);
    int seq[$];
    opcode = opc;
    op     = o;
    s      = 1'b1;
    if (opc == 3'b110 && o == 2'b10)      seq = '{1, 2, 0};
    else if (opc == 3'b110 && o == 2'b00) seq = '{1, 4, 5, 6, 0};
    else if (o == 2'b01)                  seq = '{1, 3, 4, 5, 0};
    else                                  seq = '{1, 3, 4, 5, 6, 0};
    foreach (seq[i]) push_both(seq[i]);
    n_writes = 0;
    for (int i = 0; i < seq.size(); i++) begin
      step(tag);
      if (!hold_s || i == seq.size() - 2) s = 1'b0;
    end
    check_eq({tag, "/writes"}, 16'(n_writes), 16'(exp_writes));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_writes = 0;
    reset_n  = 1'b0;
    s        = 1'b0;
    opcode   = 3'b000;
    op       = 2'b00;
    #3;
    check_eq("reset0", vec0(), exp_vec(0, 3'b000, 2'b00));
    check_eq("reset1", vec1(), exp_vec(0, 3'b000, 2'b00));
    #17;
    reset_n = 1'b1;
    push_both(0);
    step("idle");

    run_instr("mov_imm", 3'b110, 2'b10, 1'b0, 1);
    run_instr("add",     3'b101, 2'b00, 1'b0, 1);
    run_instr("and",     3'b101, 2'b10, 1'b0, 1);
    run_instr("mvn",     3'b101, 2'b11, 1'b0, 1);
    run_instr("cmp",     3'b101, 2'b01, 1'b0, 0);
    run_instr("mov_reg", 3'b110, 2'b00, 1'b1, 1);

    // Async reset landing in GET_B must abort before the next edge.
    opcode = 3'b101;
    op     = 2'b00;
    s      = 1'b1;
    push_both(1);
    push_both(3);
    push_both(4);
    step("rst_mid");
    s = 1'b0;
    step("rst_mid");
    step("rst_mid");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async0", vec0(), exp_vec(0, opcode, op));
    check_eq("rst_async1", vec1(), exp_vec(0, opcode, op));
    #2;
    reset_n = 1'b1;
    n_writes = 0;
    push_both(0);
    push_both(0);
    step("rst_after");
    step("rst_after");
    check_eq("rst_nowrite", 16'(n_writes), 16'd0);

    // Illegal encoding: instance 0 returns to WAIT, instance 1 parks in HALT.
    opcode = 3'b111;
    op     = 2'b00;
    s      = 1'b1;
    q0.push_back(exp_vec(1, opcode, op));
    q1.push_back(exp_vec(1, opcode, op));
    step("illegal");
    s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(exp_vec(0, opcode, op));
      q1.push_back(exp_vec(7, opcode, op));
      step("illegal");
    end
    // A legal instruction and s pulse cannot free the halted instance.
    opcode = 3'b110;
    op     = 2'b10;
    s      = 1'b1;
    q0.push_back(exp_vec(1, opcode, op));
    q1.push_back(exp_vec(7, opcode, op));
    step("halt_s");
    s = 1'b0;
    q0.push_back(exp_vec(2, opcode, op));
    q1.push_back(exp_vec(7, opcode, op));
    step("halt_s");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("halt_rst1", vec1(), exp_vec(0, opcode, op));
    #2;
    reset_n = 1'b1;
    push_both(0);
    step("post_halt");

    check_eq("q0_drained", 16'(q0.size()), 16'd0);
    check_eq("q1_drained", 16'(q1.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
